serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit unsigned subtractor that computes diff = a - b, LSB first, one bit per clock. It is the sequential inverse companion of the combinational full adder: a single full-subtractor cell plus a borrow flip-flop replaces a ripple chain. It serves as a lab block for shift registers, FSM control and start/done handshakes. The full-adder bench style (operands applied, result checked) is reused.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled on the edge that accepts start
b  input  WIDTH  subtrahend; sampled on the edge that accepts start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: diff/borrow_out valid
diff  output  WIDTH  result a - b mod 2^WIDTH; held until next accepted start
borrow_out  output  1  final borrow; 1 iff a < b (unsigned); held with diff
d_bit  output  1  serial difference bit produced this cycle
bit_valid  output  1  high in RUN; d_bit is meaningful

Behaviour:
- Reset: only one clock and one reset. The clock is clk. The reset is synchronous and active-low, named rst_n. rst_n is sampled on the rising edge of clk.
- State after reset: state=IDLE; busy, done, bit_valid, d_bit and borrow_out are 0; diff=0; shift registers, borrow flop and counter are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1, the block loads a into sh_a and b into sh_b. It also sets borrow=0 and cnt=0.
- RUN, bit cell: each cycle the cell takes x=sh_a[0], y=sh_b[0] and bin=borrow. It computes d = x^y^bin and bout = (~x&y) | (~(x^y)&bin).
- RUN, combinational outputs: d_bit=d and bit_valid=1.
- RUN, on each edge:
  - sh_a and sh_b shift right.
  - d is shifted into the MSB of the result register.
  - borrow <= bout.
  - cnt <= cnt+1.
- RUN -> DONE: on the edge where cnt==WIDTH-1. On that edge the result register (now complete) is copied into diff, and bout is copied into borrow_out.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditional -> IDLE.
- Latency: start is accepted on edge E0. Bits are processed on edges E1..E(WIDTH). done is high in the cycle after E(WIDTH). busy is high for exactly WIDTH cycles.
- start while RUN or DONE: ignored, with no effect on operands or result. start held high continuously restarts on the first IDLE cycle, giving a period of WIDTH+2 cycles.
- a and b are don't-care except on the accepting edge.
- diff/borrow_out: updated only on the RUN->DONE edge, stable otherwise.
- Reset mid-operation (rst_n=0 on any edge in RUN/DONE): the operation is aborted and the block returns to the reset state. No done pulse is produced and diff is cleared to 0.
- cnt width: $clog2(WIDTH). Comparison with WIDTH-1 is exact, with no wrap-around beyond WIDTH-1.
- Outputs busy, done, bit_valid, d_bit are decoded from state and the current bit cell (Moore on state). There are no combinational paths from start, a or b to any output.

Decomposition:
- Shared include/package serial_arith_defs:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - default width constant.
  - reused by a planned serial_adder.
- One sub-module full_subtractor (x, y, bin -> d, bout), purely combinational, with its own small bench. The top holds the FSM, counter, shift registers, borrow flop and result register.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start 1 cycle -> busy high 8 cycles, then done pulse; diff=0x02, borrow_out=0; d_bit sequence LSB-first 0,1,0,0,0,0,0,0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
- Boundary operands: a=0x00, b=0x00 -> diff=0x00, borrow 0. a=0xFF, b=0x01 -> 0xFE, borrow 0. a=0x00, b=0xFF -> 0x01, borrow 1.
- Pulse start=1 with a=0xAA, b=0x55 in cycle 3 of an operation computing 0x10-0x01 -> ignored; result 0x0F, borrow 0; exactly one done pulse.
- Deassert rst_n for 1 edge in RUN cycle 4 -> next cycle IDLE, all outputs 0, no done; a new start then completes normally.
- WIDTH=3, exhaustive 64 pairs (a,b), one start per pair -> {borrow_out,diff} == {1'b0,a} - {1'b0,b} for every pair; the bench stops after the last check.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now,
// serial adder later): FSM state encodings and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle of the serial subtractor. The requester drives
// start/a/b; the subtractor returns status, the serial bit stream and the
// parallel result.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             d_bit;
  logic             bit_valid;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, d_bit, bit_valid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, d_bit, bit_valid
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin = d - 2*bout. Purely combinational;
// the serial subtractor reuses this single cell once per clock.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, processed LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
// Handshake: start accepted in IDLE, busy for WIDTH cycles, then a
// one-cycle done pulse with diff/borrow_out valid and held until the next run.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             borrow_out_q;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Control FSM plus datapath: load operands, shift one bit per cycle, and
  // publish the completed result on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sh_a         <= '0;
      sh_b         <= '0;
      res          <= '0;
      diff_q       <= '0;
      borrow       <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          res    <= {cell_d, res[WIDTH-1:1]};
          borrow <= cell_bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            diff_q       <= {cell_d, res[WIDTH-1:1]};
            borrow_out_q <= cell_bout;
            cnt          <= '0;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and serial outputs depend only on the state register and the
  // current bit cell, never directly on start/a/b.
  assign bus.busy       = (state == S_RUN);
  assign bus.bit_valid  = (state == S_RUN);
  assign bus.done       = (state == S_DONE);
  assign bus.d_bit      = (state == S_RUN) & cell_d;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for the serial subtractor: an 8-bit instance for handshake, timing,
// serial stream and corner cases, a 3-bit instance swept over all operand
// pairs, and the full-subtractor cell on its own. Expected results come from
// plain unsigned arithmetic on the operands.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W3 = 3;

  logic clk;
  logic rst_n;
  int   pass_count;
  int   check_count;

  logic fs_x, fs_y, fs_bin, fs_d, fs_bout;

  serial_subtractor_if #(.WIDTH(W8)) bus8 ();
  serial_subtractor_if #(.WIDTH(W3)) bus3 ();

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_subtractor #(.WIDTH(W3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  full_subtractor u_fs (
    .x    (fs_x),
    .y    (fs_y),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {borrow, diff} of an unsigned 8-bit subtraction.
  function automatic logic [8:0] ref_sub8(input logic [7:0] av, input logic [7:0] bv);
    return {1'b0, av} - {1'b0, bv};
  endfunction

  // Runs one 8-bit operation and records what the DUT showed, cycle by cycle.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                        output int busy_n, output int done_n, output int done_at,
                        output logic [7:0] bits, output logic [7:0] dv, output logic bo);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    bits    = '0;
    dv      = '0;
    bo      = 1'b0;
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    tick();
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    for (int c = 0; c < W8 + 4; c++) begin
      if (bus8.busy) busy_n++;
      if (bus8.bit_valid && c < W8) bits[c] = bus8.d_bit;
      if (bus8.done) begin
        done_n++;
        done_at = c;
        dv = bus8.diff;
        bo = bus8.borrow_out;
      end
      tick();
    end
  endtask

  task automatic test_full_subtractor();
    int r;
    logic exp_d, exp_bout;
    for (int i = 0; i < 8; i++) begin
      fs_x   = i[2];
      fs_y   = i[1];
      fs_bin = i[0];
      #1;
      r        = int'(fs_x) - int'(fs_y) - int'(fs_bin);
      exp_bout = (r < 0);
      exp_d    = (r % 2 != 0);
      check_count++;
      if ({fs_bout, fs_d} !== {exp_bout, exp_d})
        $display("[TB] FAIL fs_cell x=%0d y=%0d bin=%0d: got bout,d=%b%b want %b%b",
                 fs_x, fs_y, fs_bin, fs_bout, fs_d, exp_bout, exp_d);
      else pass_count++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_count++;
    if ({bus8.busy, bus8.done, bus8.bit_valid, bus8.d_bit, bus8.borrow_out, bus8.diff} !== 13'd0)
      $display("[TB] FAIL reset_w8: got busy=%b done=%b bv=%b d_bit=%b bo=%b diff=%h want all 0",
               bus8.busy, bus8.done, bus8.bit_valid, bus8.d_bit, bus8.borrow_out, bus8.diff);
    else pass_count++;
    check_count++;
    if ({bus3.busy, bus3.done, bus3.bit_valid, bus3.borrow_out, bus3.diff} !== 7'd0)
      $display("[TB] FAIL reset_w3: got busy=%b done=%b bv=%b bo=%b diff=%h want all 0",
               bus3.busy, bus3.done, bus3.bit_valid, bus3.borrow_out, bus3.diff);
    else pass_count++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int busy_n, done_n, done_at;
    logic [7:0] bits, dv;
    logic bo;
    do_op8(8'h05, 8'h03, busy_n, done_n, done_at, bits, dv, bo);
    check_count++;
    if (busy_n != W8 || done_n != 1 || done_at != W8)
      $display("[TB] FAIL basic_timing: got busy=%0d done=%0d at %0d want busy=8 done=1 at 8",
               busy_n, done_n, done_at);
    else pass_count++;
    check_count++;
    if (bits !== 8'b0000_0010)
      $display("[TB] FAIL basic_stream: got bits(msb..lsb)=%b want 00000010", bits);
    else pass_count++;
    check_count++;
    if ({bo, dv} !== 9'h002)
      $display("[TB] FAIL basic_result: got bo=%b diff=%h want bo=0 diff=02", bo, dv);
    else pass_count++;
  endtask

  task automatic test_borrow();
    int busy_n, done_n, done_at;
    logic [7:0] bits, dv;
    logic bo;
    do_op8(8'h03, 8'h05, busy_n, done_n, done_at, bits, dv, bo);
    check_count++;
    if ({bo, dv} !== 9'h1FE)
      $display("[TB] FAIL borrow_result: got bo=%b diff=%h want bo=1 diff=fe", bo, dv);
    else pass_count++;
    check_count++;
    if (bits !== 8'hFE)
      $display("[TB] FAIL borrow_stream: got bits=%h want fe", bits);
    else pass_count++;
  endtask

  task automatic test_boundaries();
    logic [7:0] av [3] = '{8'h00, 8'hFF, 8'h00};
    logic [7:0] bv [3] = '{8'h00, 8'h01, 8'hFF};
    logic [8:0] ev [3] = '{9'h000, 9'h0FE, 9'h101};
    int busy_n, done_n, done_at;
    logic [7:0] bits, dv;
    logic bo;
    for (int i = 0; i < 3; i++) begin
      do_op8(av[i], bv[i], busy_n, done_n, done_at, bits, dv, bo);
      check_count++;
      if ({bo, dv} !== ev[i] || done_n != 1)
        $display("[TB] FAIL boundary %h-%h: got bo=%b diff=%h dones=%0d want %h, 1 done",
                 av[i], bv[i], bo, dv, done_n, ev[i]);
      else pass_count++;
    end
  endtask

  task automatic test_random();
    int busy_n, done_n, done_at;
    logic [7:0] bits, dv, ra, rb;
    logic [8:0] exp;
    logic bo;
    for (int i = 0; i < 16; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      exp = ref_sub8(ra, rb);
      do_op8(ra, rb, busy_n, done_n, done_at, bits, dv, bo);
      check_count++;
      if ({bo, dv} !== exp || bits !== exp[7:0] || busy_n != W8 || done_at != W8)
        $display("[TB] FAIL random %h-%h: got bo=%b diff=%h bits=%h busy=%0d done_at=%0d want %h busy=8 done_at=8",
                 ra, rb, bo, dv, bits, busy_n, done_at, exp);
      else pass_count++;
    end
  endtask

  task automatic test_ignored_start();
    int busy_n = 0;
    int done_n = 0;
    logic [7:0] dv = '0;
    logic bo = 1'b0;
    bus8.start = 1'b1;
    bus8.a     = 8'h10;
    bus8.b     = 8'h01;
    tick();
    bus8.start = 1'b0;
    for (int c = 0; c < W8 + 6; c++) begin
      if (c == 2) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_n++;
        dv = bus8.diff;
        bo = bus8.borrow_out;
      end
      tick();
    end
    check_count++;
    if ({bo, dv} !== 9'h00F || done_n != 1 || busy_n != W8)
      $display("[TB] FAIL ignored_start: got bo=%b diff=%h dones=%0d busy=%0d want diff=0f bo=0 1 done busy=8",
               bo, dv, done_n, busy_n);
    else pass_count++;
  endtask

  task automatic test_reset_mid_run();
    int stray = 0;
    int busy_n, done_n, done_at;
    logic [7:0] bits, dv;
    logic bo;
    bus8.start = 1'b1;
    bus8.a     = 8'h33;
    bus8.b     = 8'h11;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_count++;
    if ({bus8.busy, bus8.done, bus8.bit_valid, bus8.d_bit, bus8.borrow_out, bus8.diff} !== 13'd0)
      $display("[TB] FAIL reset_mid_run: got busy=%b done=%b bv=%b d_bit=%b bo=%b diff=%h want all 0",
               bus8.busy, bus8.done, bus8.bit_valid, bus8.d_bit, bus8.borrow_out, bus8.diff);
    else pass_count++;
    for (int c = 0; c < W8 + 4; c++) begin
      if (bus8.done || bus8.busy) stray++;
      tick();
    end
    check_count++;
    if (stray != 0)
      $display("[TB] FAIL reset_no_done: got %0d busy/done cycles after abort want 0", stray);
    else pass_count++;
    do_op8(8'h33, 8'h11, busy_n, done_n, done_at, bits, dv, bo);
    check_count++;
    if ({bo, dv} !== 9'h022 || done_n != 1)
      $display("[TB] FAIL reset_recover: got bo=%b diff=%h dones=%0d want diff=22 bo=0 1 done",
               bo, dv, done_n);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    logic [7:0] dv = '0;
    logic bo = 1'b0;
    logic [8:0] exp = ref_sub8(8'hC3, 8'h3C);
    bus8.start = 1'b1;
    bus8.a     = 8'hC3;
    bus8.b     = 8'h3C;
    tick();
    for (int c = 0; c < 32; c++) begin
      if (bus8.done) begin
        done_at.push_back(c);
        dv = bus8.diff;
        bo = bus8.borrow_out;
      end
      tick();
    end
    bus8.start = 1'b0;
    for (int c = 0; c < W8 + 4; c++) tick();
    check_count++;
    if (done_at.size() != 3)
      $display("[TB] FAIL b2b_count: got %0d dones want 3", done_at.size());
    else if (done_at[0] != W8 || done_at[1] - done_at[0] != W8 + 2 || done_at[2] - done_at[1] != W8 + 2)
      $display("[TB] FAIL b2b_period: got dones at %0d,%0d,%0d want 8,18,28",
               done_at[0], done_at[1], done_at[2]);
    else pass_count++;
    check_count++;
    if ({bo, dv} !== exp)
      $display("[TB] FAIL b2b_result: got bo=%b diff=%h want %h", bo, dv, exp);
    else pass_count++;
  endtask

  task automatic test_exhaustive_w3();
    logic [3:0] exp;
    logic [3:0] got;
    bit seen;
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        bus3.start = 1'b1;
        bus3.a     = 3'(ia);
        bus3.b     = 3'(ib);
        tick();
        bus3.start = 1'b0;
        bus3.a     = 3'($urandom);
        bus3.b     = 3'($urandom);
        exp  = {1'b0, 3'(ia)} - {1'b0, 3'(ib)};
        got  = '0;
        seen = 1'b0;
        for (int c = 0; c < W3 + 4 && !seen; c++) begin
          if (bus3.done) begin
            seen = 1'b1;
            got  = {bus3.borrow_out, bus3.diff};
          end
          tick();
        end
        check_count++;
        if (!seen)
          $display("[TB] FAIL w3 %0d-%0d: got no done within budget want %h", ia, ib, exp);
        else if (got !== exp)
          $display("[TB] FAIL w3 %0d-%0d: got {bo,diff}=%h want %h", ia, ib, got, exp);
        else pass_count++;
      end
    end
  endtask

  // Test sequence: reset first, then the feature scenarios, summary last.
  initial begin
    pass_count  = 0;
    check_count = 0;
    rst_n       = 1'b0;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus3.start  = 1'b0;
    bus3.a      = '0;
    bus3.b      = '0;
    fs_x        = 1'b0;
    fs_y        = 1'b0;
    fs_bin      = 1'b0;
    test_full_subtractor();
    test_reset();
    test_basic();
    test_borrow();
    test_boundaries();
    test_random();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive_w3();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
